// File: rtl/sar_adc.sv
// Successive-approximation ADC controller: binary-searches an external comparator/DAC pair MSB first.
// Optional continuous back-to-back conversion when SAR_ADC_CONT_EN is defined.
module sar_adc #(
  parameter int ADC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmp,
  input  logic                 start,
  output logic [ADC_WIDTH-1:0] DACF,
  output logic                 eoc,
  output logic                 den,
  output logic [ADC_WIDTH-1:0] Dout
);

  localparam int IW = (ADC_WIDTH > 2) ? $clog2(ADC_WIDTH) : 1;
  localparam logic [IW-1:0]        IDX_TOP  = IW'(ADC_WIDTH - 1);
  localparam logic [IW-1:0]        IDX_ONE  = IW'(1);
  localparam logic [ADC_WIDTH-1:0] MSB_CODE = {1'b1, {(ADC_WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t               state_q, state_d;
  logic [ADC_WIDTH-1:0] dacf_q, dacf_d;
  logic [ADC_WIDTH-1:0] dout_q, dout_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 eoc_q, eoc_d;
  logic                 den_q, den_d;
  logic [ADC_WIDTH-1:0] trial;

  always_comb begin
    state_d = state_q;
    dacf_d  = dacf_q;
    dout_d  = dout_q;
    idx_d   = idx_q;
    eoc_d   = 1'b0;
    den_d   = den_q;
    trial   = dacf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CONV;
          dacf_d  = MSB_CODE;
          idx_d   = IDX_TOP;
          den_d   = 1'b1;
        end
      end
      CONV: begin
        // bit idx_q is currently 1 as a trial; the comparator decides whether it stays
        if (!cmp) trial[idx_q] = 1'b0;
        if (idx_q != '0) begin
          trial[idx_q - IDX_ONE] = 1'b1;
          idx_d  = idx_q - IDX_ONE;
          dacf_d = trial;
        end else begin
          dout_d = trial;
          eoc_d  = 1'b1;
`ifdef SAR_ADC_CONT_EN
          dacf_d = MSB_CODE;
          idx_d  = IDX_TOP;
`else
          dacf_d  = trial;
          den_d   = 1'b0;
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dacf_q  <= '0;
      dout_q  <= '0;
      idx_q   <= '0;
      eoc_q   <= 1'b0;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dacf_q  <= dacf_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
      eoc_q   <= eoc_d;
      den_q   <= den_d;
    end
  end

  assign DACF = dacf_q;
  assign Dout = dout_q;
  assign eoc  = eoc_q;
  assign den  = den_q;

endmodule

// File: tb/tb_sar_adc.sv
// Scoreboard bench for sar_adc with a threshold comparator model (threshold held as 4x analog level).
module tb_sar_adc;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmp;
  logic         start;
  logic [W-1:0] DACF;
  logic         eoc;
  logic         den;
  logic [W-1:0] Dout;

  int tests_run    = 0;
  int tests_failed = 0;
  int eoc_cnt      = 0;
  int mode         = 0;   // 0 = threshold model, 1 = tied high, 2 = tied low
  int thr4         = 510;

  logic [W-1:0] sb_q[$];

  sar_adc #(.ADC_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (cmp),
    .start (start),
    .DACF  (DACF),
    .eoc   (eoc),
    .den   (den),
    .Dout  (Dout)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       cmp = 1'b1;
      2:       cmp = 1'b0;
      default: cmp = ((int'(DACF) * 4) <= thr4);
    endcase
  end

  always @(negedge clk) if (eoc === 1'b1) eoc_cnt++;

  function automatic logic [W-1:0] expected_code();
    int c;
    if (mode == 1) return '1;
    if (mode == 2) return '0;
    c = thr4 / 4;
    if (c > 255) c = 255;
    return c[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_eoc(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (eoc === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    #2;
    tests_run++;
    if ({DACF, Dout, eoc, den} !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: DACF=%h Dout=%h eoc=%b den=%b, required all zero", DACF, Dout, eoc, den);
    end
    repeat (10) tick();
    tests_run++;
    if ({DACF, Dout, eoc, den} !== '0) begin
      tests_failed++;
      $display("FAIL reset_held: DACF=%h Dout=%h eoc=%b den=%b, required all zero", DACF, Dout, eoc, den);
    end
    rst_n = 1'b1;
    tick();
  endtask

`ifndef SAR_ADC_CONT_EN
  task automatic test_midscale();
    logic [W-1:0] seq [8] = '{8'h80, 8'h40, 8'h60, 8'h70, 8'h78, 8'h7C, 8'h7E, 8'h7F};
    logic [W-1:0] exp_v;
    int den_cycles = 0;
    mode = 0;
    thr4 = 510;
    sb_q.push_back(expected_code());
    do_start();
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (DACF !== seq[k] || eoc !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_dacf[%0d]: DACF=%h eoc=%b, required DACF=%h eoc=0", k, DACF, eoc, seq[k]);
      end
      if (den === 1'b1) den_cycles++;
      tick();
    end
    exp_v = sb_q.pop_front();
    tests_run++;
    if (eoc !== 1'b1 || Dout !== exp_v || den !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_eoc: eoc=%b Dout=%h den=%b, required eoc=1 Dout=%h den=0", eoc, Dout, den, exp_v);
    end
    tests_run++;
    if (den_cycles != 8) begin
      tests_failed++;
      $display("FAIL mid_den_len: den high %0d cycles, required 8", den_cycles);
    end
    tick();
    tests_run++;
    if (eoc !== 1'b0 || DACF !== exp_v) begin
      tests_failed++;
      $display("FAIL mid_after: eoc=%b DACF=%h, required eoc=0 DACF=%h", eoc, DACF, exp_v);
    end
  endtask

  task automatic test_extremes();
    bit seen;
    int c0;
    logic [W-1:0] exp_v;
    for (int m = 1; m <= 2; m++) begin
      mode = m;
      c0 = eoc_cnt;
      sb_q.push_back(expected_code());
      do_start();
      wait_eoc(seen);
      exp_v = sb_q.pop_front();
      tests_run++;
      if (!seen || Dout !== exp_v) begin
        tests_failed++;
        $display("FAIL extreme_mode%0d: seen=%0b Dout=%h, required eoc and Dout=%h", m, seen, Dout, exp_v);
      end
      repeat (4) tick();
      tests_run++;
      if (eoc_cnt - c0 != 1) begin
        tests_failed++;
        $display("FAIL extreme_eoc_count%0d: %0d pulses, required 1", m, eoc_cnt - c0);
      end
    end
    mode = 0;
  endtask

  task automatic test_back_to_back();
    bit held = 1'b1;
    bit seen;
    logic [W-1:0] exp_v;
    mode = 0;
    thr4 = 510;
    sb_q.push_back(expected_code());
    do_start();
    repeat (8) tick();
    exp_v = sb_q.pop_front();
    tests_run++;
    if (eoc !== 1'b1 || Dout !== exp_v) begin
      tests_failed++;
      $display("FAIL b2b_first: eoc=%b Dout=%h, required eoc=1 Dout=%h", eoc, Dout, exp_v);
    end
    thr4 = 255;
    repeat (3) tick();
    sb_q.push_back(expected_code());
    do_start();
    for (int k = 0; k < 7; k++) begin
      if (Dout !== exp_v) held = 1'b0;
      tick();
    end
    if (Dout !== exp_v) held = 1'b0;
    tests_run++;
    if (!held) begin
      tests_failed++;
      $display("FAIL b2b_hold: Dout=%h changed before second eoc, required held %h", Dout, exp_v);
    end
    wait_eoc(seen);
    exp_v = sb_q.pop_front();
    tests_run++;
    if (!seen || Dout !== exp_v) begin
      tests_failed++;
      $display("FAIL b2b_second: seen=%0b Dout=%h, required Dout=%h", seen, Dout, exp_v);
    end
    tick();
  endtask

  task automatic test_start_during();
    int c0;
    logic [W-1:0] exp_v;
    mode = 0;
    thr4 = 510;
    c0 = eoc_cnt;
    sb_q.push_back(expected_code());
    do_start();
    repeat (2) tick();
    do_start();
    repeat (4) tick();
    do_start();
    exp_v = sb_q.pop_front();
    tests_run++;
    if (eoc !== 1'b1 || Dout !== exp_v) begin
      tests_failed++;
      $display("FAIL sdc_eoc: eoc=%b Dout=%h, required eoc=1 Dout=%h", eoc, Dout, exp_v);
    end
    repeat (12) tick();
    tests_run++;
    if (eoc_cnt - c0 != 1 || den !== 1'b0 || Dout !== exp_v || DACF !== exp_v) begin
      tests_failed++;
      $display("FAIL sdc_ignored: eocs=%0d den=%b Dout=%h DACF=%h, required 1 0 %h %h",
               eoc_cnt - c0, den, Dout, DACF, exp_v, exp_v);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int c0;
    bit seen;
    logic [W-1:0] exp_v;
    mode = 0;
    thr4 = 510;
    c0 = eoc_cnt;
    do_start();
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({DACF, Dout, eoc, den} !== '0) begin
      tests_failed++;
      $display("FAIL rmid_zero: DACF=%h Dout=%h eoc=%b den=%b, required all zero", DACF, Dout, eoc, den);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    tests_run++;
    if (eoc_cnt != c0) begin
      tests_failed++;
      $display("FAIL rmid_no_eoc: %0d pulses, required 0", eoc_cnt - c0);
    end
    thr4 = 255;
    sb_q.push_back(expected_code());
    do_start();
    wait_eoc(seen);
    exp_v = sb_q.pop_front();
    tests_run++;
    if (!seen || Dout !== exp_v) begin
      tests_failed++;
      $display("FAIL rmid_fresh: seen=%0b Dout=%h, required Dout=%h", seen, Dout, exp_v);
    end
    tick();
  endtask

`ifdef SAR_ADC_CONT_EN
  task automatic test_continuous();
    bit seen;
    int gap;
    logic [W-1:0] exp_v;
    mode = 0;
    thr4 = 510;
    do_start();
    for (int n = 0; n < 3; n++) begin
      sb_q.push_back(expected_code());
      gap = 0;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        gap++;
        tick();
        if (eoc === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      exp_v = sb_q.pop_front();
      tests_run++;
      if (!seen || Dout !== exp_v || den !== 1'b1 || DACF !== 8'h80) begin
        tests_failed++;
        $display("FAIL cont_result%0d: seen=%0b Dout=%h den=%b DACF=%h, required %h 1 80", n, seen, Dout, den, DACF, exp_v);
      end
      if (n > 0) begin
        tests_run++;
        if (gap != 8) begin
          tests_failed++;
          $display("FAIL cont_gap%0d: %0d cycles, required 8", n, gap);
        end
      end
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    start = 1'b0;
    test_reset();
`ifdef SAR_ADC_CONT_EN
    test_continuous();
`else
    test_midscale();
    test_extremes();
    test_back_to_back();
    test_start_during();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
